// File: rtl/irq_controller.sv
// Interrupt controller: per-source rising-edge latching, mask and fixed priority,
// and a request/ack/EOI handshake with the CPU, plus a small register port.
module irq_controller #(
    parameter int unsigned        NUM_SRC    = 4,
    parameter logic [NUM_SRC-1:0] RESET_MASK = 4'b0001,
    parameter int unsigned        ID_W       = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               global_int_en,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               irq_pin,
    output logic [ID_W-1:0]    irq_id,
    input  logic [1:0]         bus_addr,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] prev_q;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_SRC-1:0] act;
    logic [ID_W-1:0]    winner;
    logic [NUM_SRC-1:0] set_bits, w1c_bits, ack_clr;
    logic               ack_take;
    logic               unused_wdata;

    assign unused_wdata = ^bus_wdata[31:NUM_SRC];

    assign act = pending_q & mask_q;

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= RESET_MASK;
            prev_q    <= '0;
            irq_id_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            prev_q    <= irq_src;
            irq_id_q  <= irq_id_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (global_int_en && (|act)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (int_ack) begin
                    state_d = StService;
                end else if (!global_int_en || !(|act)) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq_pin   = (state_q == StReq);
        irq_id    = irq_id_q;
        bus_rdata = rdata_q;
    end

    // Id tracks the winner while requesting so a higher priority source preempts before ack.
    always_comb begin
        irq_id_d = irq_id_q;
        if (state_d == StReq) begin
            irq_id_d = winner;
        end
    end

    always_comb begin
        ack_take = (state_q == StReq) && int_ack;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_take && (irq_id_q == ID_W'(i));
        end
        set_bits = irq_src & ~prev_q;
        if (bus_we && (bus_addr == 2'd3)) begin
            set_bits = set_bits | bus_wdata[NUM_SRC-1:0];
        end
        w1c_bits = '0;
        if (bus_we && (bus_addr == 2'd1)) begin
            w1c_bits = bus_wdata[NUM_SRC-1:0];
        end
        // Sets are applied after clears so an edge always survives a same-cycle clear.
        pending_d = (pending_q & ~(w1c_bits | ack_clr)) | set_bits;
    end

    always_comb begin
        mask_d = mask_q;
        if (bus_we && (bus_addr == 2'd0)) begin
            mask_d = bus_wdata[NUM_SRC-1:0];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus_re) begin
            rdata_d = '0;
            case (bus_addr)
                2'd0: rdata_d[NUM_SRC-1:0] = mask_q;
                2'd1: rdata_d[NUM_SRC-1:0] = pending_q;
                2'd2: begin
                    rdata_d[9:8]      = state_q;
                    rdata_d[ID_W-1:0] = irq_id_q;
                end
                default: rdata_d = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed handshake scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        clr;
    logic        global_int_en;
    logic [3:0]  irq_src;
    logic        int_ack;
    logic        eoi;
    logic        irq_pin;
    logic [3:0]  irq_id;
    logic [1:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Model state: 0 idle, 1 requesting, 2 in service.
    int          m_state;
    int          m_id;
    logic [3:0]  m_pend;
    logic [3:0]  m_mask;
    logic [3:0]  m_prev;
    logic [31:0] m_rdata;

    irq_controller dut (
        .clk           (clk),
        .clr           (clr),
        .global_int_en (global_int_en),
        .irq_src       (irq_src),
        .int_ack       (int_ack),
        .eoi           (eoi),
        .irq_pin       (irq_pin),
        .irq_id        (irq_id),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [3:0] act;
        logic [3:0] set_b;
        logic [3:0] clr_b;
        int         win;
        if (clr) begin
            m_state = 0;
            m_id    = 0;
            m_pend  = 4'b0;
            m_mask  = 4'b0001;
            m_prev  = 4'b0;
            m_rdata = 32'b0;
            return;
        end
        act = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < 4; i++) begin
            if (act[i] && win < 0) win = i;
        end
        if (bus_re) begin
            case (bus_addr)
                2'd0: m_rdata = {28'b0, m_mask};
                2'd1: m_rdata = {28'b0, m_pend};
                2'd2: m_rdata = (m_state << 8) | m_id;
                default: m_rdata = 32'b0;
            endcase
        end
        set_b = irq_src & ~m_prev;
        if (bus_we && bus_addr == 2'd3) set_b = set_b | bus_wdata[3:0];
        clr_b = 4'b0;
        if (bus_we && bus_addr == 2'd1) clr_b = bus_wdata[3:0];
        if (m_state == 0) begin
            if (global_int_en && win >= 0) begin
                m_state = 1;
                m_id    = win;
            end
        end else if (m_state == 1) begin
            if (int_ack) begin
                clr_b[m_id] = 1'b1;
                m_state     = 2;
            end else if (!global_int_en || win < 0) begin
                m_state = 0;
            end else begin
                m_id = win;
            end
        end else begin
            if (eoi) m_state = 0;
        end
        m_pend = (m_pend & ~clr_b) | set_b;
        if (bus_we && bus_addr == 2'd0) m_mask = bus_wdata[3:0];
        m_prev = irq_src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_pin", {31'b0, irq_pin}, {31'b0, m_state == 1});
        chk("model_id", {28'b0, irq_id}, 32'(m_id));
        chk("model_rdata", bus_rdata, m_rdata);
        int_ack = 1'b0;
        eoi     = 1'b0;
        bus_we  = 1'b0;
        bus_re  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [1:0] a);
        bus_re   = 1'b1;
        bus_addr = a;
        tick();
    endtask

    initial begin
        clr = 1'b1; global_int_en = 1'b1; irq_src = 4'b0; int_ack = 1'b0; eoi = 1'b0;
        bus_addr = 2'd0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = 32'b0;
        m_state = 0; m_id = 0; m_pend = 4'b0; m_mask = 4'b0001; m_prev = 4'b0;
        m_rdata = 32'b0;

        tick(); tick();
        clr = 1'b0;
        chk("rst_pin", {31'b0, irq_pin}, 32'd0);
        chk("rst_id", {28'b0, irq_id}, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        rd(2'd0);
        chk("rst_mask", bus_rdata, 32'd1);

        // Timer pulse through the full handshake.
        irq_src = 4'b0001;
        rd(2'd1);
        chk("timer_pin_early", {31'b0, irq_pin}, 32'd0);
        rd(2'd1);
        chk("timer_pend", bus_rdata, 32'd1);
        chk("timer_pin", {31'b0, irq_pin}, 32'd1);
        chk("timer_id", {28'b0, irq_id}, 32'd0);
        int_ack = 1'b1; tick();
        chk("timer_ack_pin", {31'b0, irq_pin}, 32'd0);
        rd(2'd1);
        chk("timer_ack_clr", bus_rdata, 32'd0);
        eoi = 1'b1; tick();
        rd(2'd2);
        chk("timer_eoi_state", {30'b0, bus_rdata[9:8]}, 32'd0);
        irq_src = 4'b0;

        // Priority and preemption.
        wr(2'd0, 32'hF);
        irq_src = 4'b0100; tick(); tick();
        chk("pri_id2", {28'b0, irq_id}, 32'd2);
        irq_src = 4'b0110; tick(); tick();
        chk("preempt_id", {28'b0, irq_id}, 32'd1);
        int_ack = 1'b1; tick();
        chk("svc_pin", {31'b0, irq_pin}, 32'd0);
        chk("svc_id", {28'b0, irq_id}, 32'd1);
        eoi = 1'b1; tick();
        chk("gap_pin", {31'b0, irq_pin}, 32'd0);
        tick();
        chk("rereq_pin", {31'b0, irq_pin}, 32'd1);
        chk("rereq_id", {28'b0, irq_id}, 32'd2);
        int_ack = 1'b1; tick();
        eoi = 1'b1; tick();
        irq_src = 4'b0; tick();

        // Mask and global enable.
        wr(2'd0, 32'h1);
        irq_src = 4'b1000; tick(); tick(); tick();
        chk("masked_pin", {31'b0, irq_pin}, 32'd0);
        rd(2'd1);
        chk("masked_pend", bus_rdata, 32'h8);
        wr(2'd0, 32'h9);
        tick();
        chk("unmask_pin", {31'b0, irq_pin}, 32'd1);
        chk("unmask_id", {28'b0, irq_id}, 32'd3);
        global_int_en = 1'b0; tick();
        chk("gie_drop_pin", {31'b0, irq_pin}, 32'd0);
        rd(2'd1);
        chk("gie_drop_pend", bus_rdata, 32'h8);
        global_int_en = 1'b1; tick();
        int_ack = 1'b1; tick();
        eoi = 1'b1; tick();
        irq_src = 4'b0; tick();

        // Software trigger and W1C racing an edge.
        wr(2'd3, 32'h4);
        rd(2'd1);
        chk("swtrig_pend", bus_rdata, 32'h4);
        irq_src = 4'b0100;
        wr(2'd1, 32'h4);
        rd(2'd1);
        chk("w1c_vs_edge", bus_rdata, 32'h4);
        irq_src = 4'b0;
        wr(2'd1, 32'h4);
        rd(2'd1);
        chk("w1c_clear", bus_rdata, 32'h0);

        // Stray pulses and reset mid-service.
        int_ack = 1'b1; tick();
        rd(2'd2);
        chk("ack_in_idle", {30'b0, bus_rdata[9:8]}, 32'd0);
        wr(2'd0, 32'hF);
        wr(2'd3, 32'h1);
        tick();
        chk("sw_req_pin", {31'b0, irq_pin}, 32'd1);
        eoi = 1'b1; tick();
        chk("eoi_in_req", {31'b0, irq_pin}, 32'd1);
        int_ack = 1'b1; tick();
        chk("svc2_pin", {31'b0, irq_pin}, 32'd0);
        clr = 1'b1; tick();
        clr = 1'b0;
        chk("clr_pin", {31'b0, irq_pin}, 32'd0);
        chk("clr_id", {28'b0, irq_id}, 32'd0);
        chk("clr_rdata", bus_rdata, 32'd0);
        rd(2'd0);
        chk("clr_mask", bus_rdata, 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
            global_int_en = ($urandom_range(0, 7) != 0);
            int_ack       = ($urandom_range(0, 3) == 0);
            eoi           = ($urandom_range(0, 3) == 0);
            bus_we        = ($urandom_range(0, 5) == 0);
            bus_re        = ($urandom_range(0, 2) == 0);
            bus_addr      = 2'($urandom);
            bus_wdata     = $urandom;
            clr           = ($urandom_range(0, 199) == 0);
            tick();
        end
        clr = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
